// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-message lock in front of an 8N1 UART transmitter.
// A granted requester owns the line until it sends a byte flagged last (or its lock times out).
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    uart_txd,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW      = $clog2(NREQ);
    localparam int IW1     = IW + 1;
    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int TW      = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int TO_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           lock_q, lock_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [TW-1:0]  idle_q, idle_d;

    logic [NREQ-1:0][7:0] data_arr;
    logic [IW-1:0]        sel;
    logic                 found;
    logic [IW1-1:0]       idx;

    assign data_arr = req_data;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) return '0;
        return i + IW'(1);
    endfunction

    // Selection only looks at requesters while the serializer is idle.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        idx   = '0;
        if (state_q == IDLE && !reset_reset) begin
            if (lock_q) begin
                sel   = owner_q;
                found = req_valid[owner_q];
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = {1'b0, rr_q} + IW1'(k);
                    if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
                    if (!found && req_valid[idx[IW-1:0]]) begin
                        found = 1'b1;
                        sel   = idx[IW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) req_ready[sel] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = START;
                    cnt_d   = '0;
                    shift_d = data_arr[sel];
                    txd_d   = 1'b0;
                    grant_d = sel;
                    idle_d  = '0;
                    if (req_last[sel]) begin
                        lock_d = 1'b0;
                        rr_d   = next_idx(sel);
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = sel;
                    end
                end else if (LOCK_TIMEOUT > 0 && lock_q && !req_valid[owner_q]) begin
                    // Stalled owner: release the line so others are not starved.
                    if (idle_q == TW'(TO_LAST)) begin
                        lock_d = 1'b0;
                        rr_d   = next_idx(owner_q);
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
            end
            START: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            lock_q  <= 1'b0;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            idle_q  <= idle_d;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = (state_q != IDLE) || lock_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level arbitration model feeds a scoreboard,
// a serial-line monitor decodes frames and checks them against it.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int CPB  = 4;
    localparam int TO   = 16;
    localparam int LINE = 10 * CPB + 1;   // accept-to-next-accept spacing

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        uart_txd;
    logic        busy;
    logic [1:0]  grant_id;

    always #5 clk_clk = ~clk_clk;

    uart_tx_arbiter #(.NREQ(NREQ), .CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(TO)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .uart_txd(uart_txd), .busy(busy), .grant_id(grant_id)
    );

    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;

    int checks = 0, errors = 0, cyc = 0;
    int m_free_at = 0, m_rr = 0, m_owner = 0, m_idle = 0;
    bit m_lock = 1'b0;
    exp_t sb[$];
    logic [8:0] rbuf [4][16];
    int rhd[4], rcnt[4];
    bit en[4];
    int acc_id[$], acc_cyc[$], start_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rbuf[i][(rhd[i] + rcnt[i]) % 16] = {l, d};
        rcnt[i]++;
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            h = rbuf[i][rhd[i]];
            req_valid[i]       = (rcnt[i] > 0) && en[i];
            req_data[8*i +: 8] = h[7:0];
            req_last[i]        = h[8];
        end
    endtask

    // One clock: check/model at the falling edge, then apply handshakes and re-drive.
    task automatic tick();
        logic [3:0] v, hs, exp_rdy;
        logic [8:0] h;
        int sel, j, ac;
        @(negedge clk_clk);
        v  = req_valid;
        hs = req_valid & req_ready;
        ac = cyc;
        chk("busy", {31'd0, busy}, {31'd0, (cyc < m_free_at) || m_lock});
        if (reset_reset) begin
            chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
            m_free_at = cyc + 1;
            m_lock = 1'b0; m_rr = 0; m_owner = 0; m_idle = 0;
            sb.delete();
        end else begin
            sel = -1;
            exp_rdy = '0;
            if (cyc >= m_free_at) begin
                if (m_lock) begin
                    if (v[m_owner]) sel = m_owner;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        j = (m_rr + k) % 4;
                        if (sel < 0 && v[j]) sel = j;
                    end
                end
                if (sel >= 0) exp_rdy[sel] = 1'b1;
            end
            chk("ready", {28'd0, req_ready}, {28'd0, exp_rdy});
            if (sel >= 0) begin
                h = rbuf[sel][rhd[sel]];
                sb.push_back('{id: 2'(sel), data: h[7:0]});
                m_free_at = cyc + LINE;
                m_idle = 0;
                if (h[8]) begin m_lock = 1'b0; m_rr = (sel + 1) % 4; end
                else begin m_lock = 1'b1; m_owner = sel; end
            end else if (cyc >= m_free_at && m_lock && !v[m_owner]) begin
                m_idle++;
                if (m_idle == TO) begin m_lock = 1'b0; m_rr = (m_owner + 1) % 4; m_idle = 0; end
            end
        end
        @(posedge clk_clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                rhd[i] = (rhd[i] + 1) % 16;
                rcnt[i]--;
                acc_id.push_back(i);
                acc_cyc.push_back(ac);
            end
        end
        drive();
    endtask

    task automatic do_reset(input string tag);
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        #1;
        chk({tag, "_txd"}, {31'd0, uart_txd}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_grant"}, {30'd0, grant_id}, 32'd0);
        chk({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!((rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3]) == 0 && cyc >= m_free_at + 1 && !m_lock)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=%0d cycles required<%0d", n, budget);
        end
        tick();
    endtask

    task automatic clr_logs();
        acc_id.delete();
        acc_cyc.delete();
    endtask

    task automatic chk_order(input string name, input int exp_ids[$]);
        chk({name, "_count"}, acc_id.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size() && i < acc_id.size(); i++)
            chk({name, "_id"}, acc_id[i], exp_ids[i]);
    endtask

    // Serial monitor: decodes every frame, compares with the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        logic [1:0] gid;
        bit shape_ok, aborted;
        int bi;
        exp_t e;
        forever begin
            @(negedge clk_clk);
            if (reset_reset !== 1'b0 || uart_txd !== 1'b0) continue;
            start_log.push_back(cyc);
            gid = grant_id;
            b = 8'd0;
            shape_ok = 1'b1;
            aborted = 1'b0;
            for (int k = 0; k < 10 * CPB; k++) begin
                if (k > 0) @(negedge clk_clk);
                if (reset_reset) begin aborted = 1'b1; break; end
                bi = k / CPB;
                if (bi == 0) begin
                    if (uart_txd !== 1'b0) shape_ok = 1'b0;
                end else if (bi == 9) begin
                    if (uart_txd !== 1'b1) shape_ok = 1'b0;
                end else if (k % CPB == 0) begin
                    b[3'(bi - 1)] = uart_txd;
                end else if (uart_txd !== b[3'(bi - 1)]) begin
                    shape_ok = 1'b0;
                end
            end
            if (!aborted) begin
                chk("frame_shape", {31'd0, shape_ok}, 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: actual byte=0x%0h required=no frame", b);
                end else begin
                    e = sb.pop_front();
                    chk("frame_data", {24'd0, b}, {24'd0, e.data});
                    chk("frame_grant", {30'd0, gid}, {30'd0, e.id});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a, pushed, len;
        for (int i = 0; i < 4; i++) begin
            rhd[i] = 0; rcnt[i] = 0; en[i] = 1'b1;
            for (int k = 0; k < 16; k++) rbuf[i][k] = 9'd0;
        end
        @(posedge clk_clk);
        #1;
        do_reset("rst");

        // Single byte timing, plus a second byte to see ready return
        clr_logs();
        push(0, 8'h55, 1'b1);
        push(0, 8'h55, 1'b1);
        drive();
        drain(500);
        chk("t1_count", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) chk("t1_ready_again", acc_cyc[1] - acc_cyc[0], LINE);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Round robin across all requesters
        do_reset("t2rst");
        clr_logs();
        push(0, 8'h10, 1'b1); push(1, 8'h21, 1'b1); push(2, 8'h32, 1'b1);
        push(3, 8'h43, 1'b1); push(0, 8'h14, 1'b1);
        drive();
        drain(1000);
        chk_order("t2", '{0, 1, 2, 3, 0});

        // Message lock holds off a competing requester
        do_reset("t3rst");
        clr_logs();
        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
        push(2, 8'hB2, 1'b1);
        drive();
        drain(1000);
        chk_order("t3", '{1, 1, 1, 2});

        // Lock timeout after the owner goes quiet
        do_reset("t4rst");
        clr_logs();
        push(0, 8'h5A, 1'b0);
        push(3, 8'hC3, 1'b1);
        drive();
        drain(1000);
        chk_order("t4", '{0, 3});
        if (acc_cyc.size() == 2) chk("t4_timeout_cycle", acc_cyc[1] - acc_cyc[0], LINE + TO);

        // Reset while data bit 3 is on the line
        do_reset("t5rst");
        clr_logs();
        push(0, 8'h96, 1'b1);
        drive();
        a = 0;
        while (acc_cyc.size() == 0 && a < 100) begin tick(); a++; end
        chk("t5_accepted", acc_cyc.size(), 1);
        if (acc_cyc.size() > 0) begin
            a = acc_cyc[0] + 1 + CPB * 4 + 1;
            while (cyc < a) tick();
        end
        do_reset("t5mid");
        clr_logs();
        push(0, 8'h3C, 1'b1);
        drive();
        drain(500);
        chk("t5_after_count", acc_id.size(), 1);

        // Back-to-back bytes leave exactly one idle cycle
        start_log.delete();
        push(2, 8'h00, 1'b0);
        push(2, 8'hFF, 1'b1);
        drive();
        drain(500);
        chk("t6_frames", start_log.size(), 2);
        if (start_log.size() == 2) chk("t6_start_gap", start_log[1] - start_log[0], LINE);

        // Random traffic with valid gaps and multi-byte messages
        pushed = 0;
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < 4; i++) begin
                en[i] = ($urandom_range(7) != 0);
                if (pushed < 80 && rcnt[i] < 8 && $urandom_range(24) == 0) begin
                    len = $urandom_range(3, 1);
                    for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
                    pushed += len;
                end
            end
            drive();
            tick();
        end
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        drive();
        drain(6000);
        chk("sb_empty", sb.size(), 0);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
